// File: rtl/mp_shared_mem.sv
// -----------------------------------------------------------------------------
// mp_shared_mem
// Single-ported shared data memory for a small multiprocessor (up to four
// cores on one request channel). One transaction is handled at a time:
// a single access, a 4-beat incrementing burst, or an atomic
// fetch-and-increment. Every accepted transaction is tagged with a
// sequential 4-bit burst_id.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous reset, active HIGH (name kept from the codebase)
//   core_id   - requesting core number (0..3)
//   opcode    - 00 single, 01 burst4, 10 fetch-and-increment, 11 reserved
//   req       - request valid (held by requester until gnt)
//   gnt       - one-cycle pulse: request accepted, first beat executing
//   we        - 1 = write, 0 = read (ignored for fetch-and-increment)
//   addr      - start word address
//   data_in   - write data (burst beats k>=1 sample it one cycle ahead)
//   rvalid    - data_out valid this cycle
//   data_out  - read data, holds its value while rvalid = 0
//   burst_id  - tag of the current or most recent transaction
//
// Build option:
//   MP_REGION_PROTECT_EN - when defined, the memory is split into four
//   regions by addr[AW-1:AW-2]; writes (and atomic increments) into a
//   region that differs from the requesting core_id are silently dropped.
// -----------------------------------------------------------------------------
module mp_shared_mem #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    core_id,
    input  logic [1:0]    opcode,
    input  logic          req,
    output logic          gnt,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic          rvalid,
    output logic [DW-1:0] data_out,
    output logic [3:0]    burst_id
);

    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_BURST  = 2'b01;
    localparam logic [1:0] OP_ATOMIC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [DW-1:0] r_mem [2**AW];

    logic [1:0]    r_op;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [1:0]    r_beatCnt;
    logic [3:0]    r_tagCnt;

    logic          w_accept;
    logic          w_isBeat;
    logic          w_lastBeat;
    logic [AW-1:0] w_beatAddr;
    logic          w_doRead;
    logic          w_wantWrite;
    logic          w_writeAllow;
    logic          w_doWrite;
    logic [DW-1:0] w_wrData;

    // Address of the beat executing this cycle; a burst simply wraps at the
    // top of memory because the add is truncated to AW bits.
    assign w_beatAddr = r_addr + AW'(r_beatCnt);
    assign w_isBeat   = (r_state == BEAT);
    assign w_lastBeat = (r_op != OP_BURST) || (r_beatCnt == 2'd3);

    // Fetch-and-increment is both a read and a write in the same beat; the
    // reserved opcode touches nothing.
    assign w_doRead    = w_isBeat &&
                         ((((r_op == OP_SINGLE) || (r_op == OP_BURST)) && !r_we) ||
                          (r_op == OP_ATOMIC));
    assign w_wantWrite = w_isBeat &&
                         ((((r_op == OP_SINGLE) || (r_op == OP_BURST)) && r_we) ||
                          (r_op == OP_ATOMIC));
    assign w_doWrite   = w_wantWrite && w_writeAllow;
    assign w_wrData    = (r_op == OP_ATOMIC) ? (r_mem[w_beatAddr] + DW'(1)) : r_data;

`ifdef MP_REGION_PROTECT_EN
    logic [1:0] r_core;

    // The requesting core is remembered so that every beat of the
    // transaction can be checked against the region of its own address.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_core <= 2'd0;
        end else if (w_accept) begin
            r_core <= core_id;
        end
    end

    assign w_writeAllow = (w_beatAddr[AW-1:AW-2] == r_core);
`else
    logic w_unusedCore;

    // Without region protection the core number has no influence on access.
    assign w_unusedCore = ^core_id;
    assign w_writeAllow = 1'b1;
`endif

    // State register for the IDLE -> BEAT -> DONE transaction sequence.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. gnt is raised only on the first beat so it is a
    // single-cycle pulse even for bursts; requests outside IDLE are ignored.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        gnt         = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_nextState = BEAT;
                end
            end
            BEAT: begin
                gnt = (r_beatCnt == 2'd0);
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, beat counting and tag generation. During a burst the
    // write data register reloads every beat, so beat k writes the data_in
    // value that was present at the edge ending the previous beat.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_op      <= OP_SINGLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_beatCnt <= 2'd0;
            r_tagCnt  <= 4'd0;
            burst_id  <= 4'd0;
        end else if (w_accept) begin
            r_op      <= opcode;
            r_we      <= we;
            r_addr    <= addr;
            r_data    <= data_in;
            r_beatCnt <= 2'd0;
            burst_id  <= r_tagCnt;
            r_tagCnt  <= r_tagCnt + 4'd1;
        end else if (w_isBeat) begin
            r_beatCnt <= r_beatCnt + 2'd1;
            r_data    <= data_in;
        end
    end

    // Memory array. Reset clears every word, which also guarantees that a
    // transaction interrupted by reset leaves no partial write behind.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doWrite) begin
            r_mem[w_beatAddr] <= w_wrData;
        end
    end

    // Read return path: the old contents of the beat address appear one
    // cycle after the beat, and data_out holds between reads.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rvalid   <= 1'b0;
            data_out <= '0;
        end else begin
            rvalid <= w_doRead;
            if (w_doRead) begin
                data_out <= r_mem[w_beatAddr];
            end
        end
    end

endmodule

// File: tb/tb_mp_shared_mem.sv
// -----------------------------------------------------------------------------
// tb_mp_shared_mem
// Directed self-checking bench for mp_shared_mem. Inputs are driven and
// outputs sampled on the falling clock edge; expected values are written
// out by hand for each directed vector.
// -----------------------------------------------------------------------------
module tb_mp_shared_mem;

    logic        clk;
    logic        rst_n;
    logic [1:0]  core_id;
    logic [1:0]  opcode;
    logic        req;
    logic        gnt;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data_in;
    logic        rvalid;
    logic [7:0]  data_out;
    logic [3:0]  burst_id;

    int checkCount = 0;
    int errorCount = 0;

    mp_shared_mem #(.AW(11), .DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .core_id  (core_id),
        .opcode   (opcode),
        .req      (req),
        .gnt      (gnt),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .rvalid   (rvalid),
        .data_out (data_out),
        .burst_id (burst_id)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for two cycles, release it on a falling edge.
    task automatic resetDut();
        rst_n = 1'b1;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Raise a request and wait (bounded) for its gnt; returns on the falling
    // edge inside the gnt cycle with req already dropped.
    task automatic applyStimulus(input logic [1:0] c, input logic [1:0] op,
                                 input logic w, input logic [10:0] a,
                                 input logic [7:0] d);
        bit seen;
        seen    = 1'b0;
        core_id = c;
        opcode  = op;
        we      = w;
        addr    = a;
        data_in = d;
        req     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("gntTimeout", 16'(0), 16'(1));
        req = 1'b0;
    endtask

    // Single read that checks the returned word one cycle after gnt.
    task automatic readCheck(input string tag, input logic [10:0] a,
                             input logic [7:0] expData);
        applyStimulus(2'd0, 2'b00, 1'b0, a, 8'h00);
        @(negedge clk);
        checkOutput({tag, "_rvalid"}, 16'(rvalid), 16'(1));
        checkOutput({tag, "_data"}, 16'(data_out), 16'(expData));
    endtask

    // Four-beat write burst; data for beats 1..3 is presented one cycle ahead.
    task automatic writeBurst(input logic [10:0] a, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3);
        applyStimulus(2'd0, 2'b01, 1'b1, a, d0);
        data_in = d1;
        @(negedge clk);
        data_in = d2;
        @(negedge clk);
        data_in = d3;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] burstExp [4];
        int gap;
        int rvalidSeen;
        bit seen;

        core_id = 2'd0;
        opcode  = 2'b00;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;
        req     = 1'b0;
        rst_n   = 1'b1;

        // ---------------- reset state ----------------
        resetDut();
        checkOutput("rst_gnt", 16'(gnt), 16'(0));
        checkOutput("rst_rvalid", 16'(rvalid), 16'(0));
        checkOutput("rst_dataOut", 16'(data_out), 16'(0));
        checkOutput("rst_burstId", 16'(burst_id), 16'(0));

        // ---------------- single write then read ----------------
        applyStimulus(2'd0, 2'b00, 1'b1, 11'h010, 8'hA5);
        checkOutput("wr_burstId", 16'(burst_id), 16'(0));
        @(negedge clk);
        checkOutput("wr_noRvalid", 16'(rvalid), 16'(0));
        applyStimulus(2'd0, 2'b00, 1'b0, 11'h010, 8'h00);
        checkOutput("rd_burstId", 16'(burst_id), 16'(1));
        @(negedge clk);
        checkOutput("rd_rvalid", 16'(rvalid), 16'(1));
        checkOutput("rd_data", 16'(data_out), 16'hA5);

        // ---------------- wrapping burst write / read ----------------
        writeBurst(11'h7FE, 8'h11, 8'h22, 8'h33, 8'h44);
        burstExp[0] = 8'h11;
        burstExp[1] = 8'h22;
        burstExp[2] = 8'h33;
        burstExp[3] = 8'h44;
        applyStimulus(2'd0, 2'b01, 1'b0, 11'h7FE, 8'h00);
        checkOutput("brd_burstId", 16'(burst_id), 16'(3));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("brd_rvalid%0d", k), 16'(rvalid), 16'(1));
            checkOutput($sformatf("brd_data%0d", k), 16'(data_out), 16'(burstExp[k]));
        end
        @(negedge clk);
        checkOutput("brd_rvalidEnd", 16'(rvalid), 16'(0));
        checkOutput("brd_dataHold", 16'(data_out), 16'h44);
        readCheck("wrapAddr0", 11'h000, 8'h33);

        // ---------------- atomic fetch-and-increment ----------------
        applyStimulus(2'd0, 2'b00, 1'b1, 11'h020, 8'hFF);
        // we=1 on purpose: it must be ignored for the atomic opcode
        applyStimulus(2'd0, 2'b10, 1'b1, 11'h020, 8'h55);
        @(negedge clk);
        checkOutput("atomic_rvalid", 16'(rvalid), 16'(1));
        checkOutput("atomic_old", 16'(data_out), 16'hFF);
        readCheck("atomic_new", 11'h020, 8'h00);

        // ---------------- req held high through a burst ----------------
        core_id = 2'd0;
        opcode  = 2'b01;
        we      = 1'b0;
        addr    = 11'h7FE;
        req     = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("held_firstGnt", 16'(seen), 16'(1));
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (gnt) break;
        end
        req = 1'b0;
        checkOutput("held_gntGap", 16'(gap), 16'(6));

        // ---------------- reset during a read burst ----------------
        writeBurst(11'h030, 8'h77, 8'h78, 8'h79, 8'h7A);
        applyStimulus(2'd0, 2'b01, 1'b0, 11'h030, 8'h00);
        @(negedge clk);
        checkOutput("mid_beat0", 16'(data_out), 16'h77);
        @(negedge clk);
        checkOutput("mid_beat1", 16'(data_out), 16'h78);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        checkOutput("mid_rstRvalid", 16'(rvalid), 16'(0));
        checkOutput("mid_rstData", 16'(data_out), 16'(0));
        rvalidSeen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rvalid) rvalidSeen++;
        end
        checkOutput("mid_noMoreRvalid", 16'(rvalidSeen), 16'(0));
        applyStimulus(2'd0, 2'b00, 1'b0, 11'h030, 8'h00);
        checkOutput("mid_tagRestart", 16'(burst_id), 16'(0));
        @(negedge clk);
        checkOutput("mid_memCleared", 16'(data_out), 16'(0));
        readCheck("mid_memCleared2", 11'h032, 8'h00);

        // ---------------- region protection ----------------
        applyStimulus(2'd1, 2'b00, 1'b1, 11'h000, 8'h5A);
`ifdef MP_REGION_PROTECT_EN
        readCheck("region_foreign", 11'h000, 8'h00);
`else
        readCheck("region_foreign", 11'h000, 8'h5A);
`endif
        applyStimulus(2'd0, 2'b00, 1'b1, 11'h000, 8'h5A);
        readCheck("region_own", 11'h000, 8'h5A);

        // ---------------- 20 back-to-back requests, tag wrap ----------------
        resetDut();
        core_id = 2'd2;
        opcode  = 2'b11;
        we      = 1'b1;
        addr    = 11'h100;
        data_in = 8'hEE;
        req     = 1'b1;
        rvalidSeen = 0;
        for (int n = 0; n < 20; n++) begin
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rvalid) rvalidSeen++;
                if (gnt) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) checkOutput("b2b_gntTimeout", 16'(0), 16'(1));
            checkOutput($sformatf("b2b_burstId%0d", n), 16'(burst_id), 16'(n % 16));
        end
        req = 1'b0;
        checkOutput("b2b_noRvalid", 16'(rvalidSeen), 16'(0));
        readCheck("reserved_noWrite", 11'h100, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Hard stop in case a task ever stalls despite its own bounds.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
